// File: rtl/rf_access_scheduler_pkg.sv
// rtl/rf_access_scheduler_pkg.sv - shared widths and record types for the RF access scheduler
package rf_sched_pkg;

  localparam int NUM_REQ = 4;
  localparam int WARP_W  = 6;
  localparam int REG_W   = 5;
  localparam int THREADS = 32;
  localparam int DATA_W  = THREADS * 32;

  typedef struct packed {
    logic [WARP_W-1:0] warp;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic              wr;
  } issue_req_t;

  typedef struct packed {
    logic [WARP_W-1:0] warp;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic [31:0]       mask;
  } wb_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
  } operand_bundle_t;

endpackage

// File: rtl/rf_access_scheduler_if.sv
// rtl/rf_access_scheduler_if.sv - issue, register-file, dispatch, writeback and perf signals
interface rf_access_scheduler_if #(
  parameter int NUM_REQ          = 4,
  parameter int THREADS_PER_WARP = 32
);
  import rf_sched_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int DW   = THREADS_PER_WARP * 32;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][WARP_W-1:0] req_warp;
  logic [NUM_REQ-1:0][REG_W-1:0]  req_rs1;
  logic [NUM_REQ-1:0][REG_W-1:0]  req_rs2;
  logic [NUM_REQ-1:0][REG_W-1:0]  req_rd;
  logic [NUM_REQ-1:0]             req_wr;

  logic [REG_W-1:0]  rf_rs1_addr;
  logic [REG_W-1:0]  rf_rs2_addr;
  logic [WARP_W-1:0] rf_rs1_warp;
  logic [WARP_W-1:0] rf_rs2_warp;
  logic [DW-1:0]     rf_rs1_data;
  logic [DW-1:0]     rf_rs2_data;

  logic              out_valid;
  logic              out_ready;
  logic [ID_W-1:0]   out_req_id;
  logic [WARP_W-1:0] out_warp;
  logic [REG_W-1:0]  out_rd;
  logic              out_wr;
  logic [DW-1:0]     out_op_a;
  logic [DW-1:0]     out_op_b;

  logic              wb_alu_valid;
  logic              wb_alu_ready;
  logic [WARP_W-1:0] wb_alu_warp;
  logic [REG_W-1:0]  wb_alu_rd;
  logic [DW-1:0]     wb_alu_data;
  logic [31:0]       wb_alu_mask;

  logic              wb_mem_valid;
  logic              wb_mem_ready;
  logic [WARP_W-1:0] wb_mem_warp;
  logic [REG_W-1:0]  wb_mem_rd;
  logic [DW-1:0]     wb_mem_data;
  logic [31:0]       wb_mem_mask;

  logic [REG_W-1:0]  rf_rd_addr;
  logic [WARP_W-1:0] rf_rd_warp;
  logic [DW-1:0]     rf_rd_data;
  logic [31:0]       rf_rd_thread_mask;
  logic              rf_write_en;

  logic [31:0] perf_grants;
  logic [31:0] perf_hazard_stalls;
  logic [31:0] perf_out_stalls;

  modport master (
    input  req_valid, req_warp, req_rs1, req_rs2, req_rd, req_wr,
    input  rf_rs1_data, rf_rs2_data, out_ready,
    input  wb_alu_valid, wb_alu_warp, wb_alu_rd, wb_alu_data, wb_alu_mask,
    input  wb_mem_valid, wb_mem_warp, wb_mem_rd, wb_mem_data, wb_mem_mask,
    output req_ready, rf_rs1_addr, rf_rs2_addr, rf_rs1_warp, rf_rs2_warp,
    output out_valid, out_req_id, out_warp, out_rd, out_wr, out_op_a, out_op_b,
    output wb_alu_ready, wb_mem_ready,
    output rf_rd_addr, rf_rd_warp, rf_rd_data, rf_rd_thread_mask, rf_write_en,
    output perf_grants, perf_hazard_stalls, perf_out_stalls
  );

  modport slave (
    output req_valid, req_warp, req_rs1, req_rs2, req_rd, req_wr,
    output rf_rs1_data, rf_rs2_data, out_ready,
    output wb_alu_valid, wb_alu_warp, wb_alu_rd, wb_alu_data, wb_alu_mask,
    output wb_mem_valid, wb_mem_warp, wb_mem_rd, wb_mem_data, wb_mem_mask,
    input  req_ready, rf_rs1_addr, rf_rs2_addr, rf_rs1_warp, rf_rs2_warp,
    input  out_valid, out_req_id, out_warp, out_rd, out_wr, out_op_a, out_op_b,
    input  wb_alu_ready, wb_mem_ready,
    input  rf_rd_addr, rf_rd_warp, rf_rd_data, rf_rd_thread_mask, rf_write_en,
    input  perf_grants, perf_hazard_stalls, perf_out_stalls
  );

endinterface

// File: rtl/rf_access_scheduler_rr_arbiter.sv
// rtl/rf_access_scheduler_rr_arbiter.sv - round-robin one-hot arbiter, search starts at ptr
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (((int'(ptr) + k) % N) == j)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_access_scheduler.sv
// rtl/rf_access_scheduler.sv - scoreboarded operand-read scheduler with writeback port arbitration
module rf_access_scheduler #(
  parameter int NUM_REQ          = 4,
  parameter int NUM_WARPS        = 32,
  parameter int NUM_REGISTERS    = 32,
  parameter int THREADS_PER_WARP = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  rf_access_scheduler_if.master bus
);
  import rf_sched_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int DW   = THREADS_PER_WARP * 32;

  typedef logic [NUM_WARPS-1:0][NUM_REGISTERS-1:0] sb_t;

  sb_t               busy_q;
  sb_t               set_mask;
  sb_t               clr_mask;
  logic [ID_W-1:0]   rr_ptr_q;
  logic              out_valid_q;
  logic [ID_W-1:0]   out_id_q;
  logic [WARP_W-1:0] out_warp_q;
  logic [REG_W-1:0]  out_rd_q;
  logic              out_wr_q;
  logic [DW-1:0]     out_op_a_q;
  logic [DW-1:0]     out_op_b_q;
  logic [31:0]       grants_q;
  logic [31:0]       hazard_q;
  logic [31:0]       ostall_q;

  issue_req_t        reqs [NUM_REQ];
  issue_req_t        sel;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic              grant_any;
  logic [ID_W-1:0]   grant_id;
  logic              slot_free;
  operand_bundle_t   rf_ops;
  wb_req_t           wb;
  logic              wb_fire;

  function automatic logic is_busy(input sb_t sb, input logic [WARP_W-1:0] w,
                                   input logic [REG_W-1:0] r);
    logic [NUM_REGISTERS-1:0] row;
    row = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (w == WARP_W'(i)) row = sb[i];
    end
    return row[r];
  endfunction

  // Eligibility looks only at pre-edge busy state: a register freed this cycle issues next cycle.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqs[i].warp = bus.req_warp[i];
      reqs[i].rs1  = bus.req_rs1[i];
      reqs[i].rs2  = bus.req_rs2[i];
      reqs[i].rd   = bus.req_rd[i];
      reqs[i].wr   = bus.req_wr[i];
      elig[i] = bus.req_valid[i]
             && !is_busy(busy_q, reqs[i].warp, reqs[i].rs1)
             && !is_busy(busy_q, reqs[i].warp, reqs[i].rs2)
             && !(reqs[i].wr && is_busy(busy_q, reqs[i].warp, reqs[i].rd));
    end
  end

  assign slot_free = !out_valid_q || bus.out_ready;
  assign arb_req   = slot_free ? elig : '0;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  assign grant_any = |grant;

  // sel stays all-zero without a grant, which also zeroes the RF read address/warp.
  always_comb begin
    sel      = '0;
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel      = reqs[i];
        grant_id = ID_W'(i);
      end
    end
  end

  assign bus.req_ready   = grant;
  assign bus.rf_rs1_addr = sel.rs1;
  assign bus.rf_rs2_addr = sel.rs2;
  assign bus.rf_rs1_warp = sel.warp;
  assign bus.rf_rs2_warp = sel.warp;

  assign rf_ops.op_a = bus.rf_rs1_data;
  assign rf_ops.op_b = bus.rf_rs2_data;

  assign bus.wb_mem_ready = 1'b1;
  assign bus.wb_alu_ready = !bus.wb_mem_valid;

  always_comb begin
    wb      = '0;
    wb_fire = 1'b0;
    if (bus.wb_mem_valid) begin
      wb.warp = bus.wb_mem_warp;
      wb.rd   = bus.wb_mem_rd;
      wb.data = bus.wb_mem_data;
      wb.mask = bus.wb_mem_mask;
      wb_fire = 1'b1;
    end else if (bus.wb_alu_valid) begin
      wb.warp = bus.wb_alu_warp;
      wb.rd   = bus.wb_alu_rd;
      wb.data = bus.wb_alu_data;
      wb.mask = bus.wb_alu_mask;
      wb_fire = 1'b1;
    end
  end

  assign bus.rf_write_en       = wb_fire && (wb.rd != '0);
  assign bus.rf_rd_addr        = wb.rd;
  assign bus.rf_rd_warp        = wb.warp;
  assign bus.rf_rd_data        = wb.data;
  assign bus.rf_rd_thread_mask = wb.mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      for (int r = 1; r < NUM_REGISTERS; r++) begin
        if (grant_any && sel.wr && sel.warp == WARP_W'(w) && sel.rd == REG_W'(r))
          set_mask[w][r] = 1'b1;
        if (wb_fire && wb.warp == WARP_W'(w) && wb.rd == REG_W'(r))
          clr_mask[w][r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_warp_q  <= '0;
      out_rd_q    <= '0;
      out_wr_q    <= 1'b0;
      out_op_a_q  <= '0;
      out_op_b_q  <= '0;
      grants_q    <= '0;
      hazard_q    <= '0;
      ostall_q    <= '0;
    end else begin
      // Set is applied after clear so an issue to the same register wins over its writeback.
      busy_q <= (busy_q & ~clr_mask) | set_mask;
      if (grant_any) begin
        rr_ptr_q    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        out_valid_q <= 1'b1;
        out_id_q    <= grant_id;
        out_warp_q  <= sel.warp;
        out_rd_q    <= sel.rd;
        out_wr_q    <= sel.wr;
        out_op_a_q  <= rf_ops.op_a;
        out_op_b_q  <= rf_ops.op_b;
        grants_q    <= grants_q + 32'd1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if ((|bus.req_valid) && !(|elig)) hazard_q <= hazard_q + 32'd1;
      if (out_valid_q && !bus.out_ready) ostall_q <= ostall_q + 32'd1;
    end
  end

  assign bus.out_valid          = out_valid_q;
  assign bus.out_req_id         = out_id_q;
  assign bus.out_warp           = out_warp_q;
  assign bus.out_rd             = out_rd_q;
  assign bus.out_wr             = out_wr_q;
  assign bus.out_op_a           = out_op_a_q;
  assign bus.out_op_b           = out_op_b_q;
  assign bus.perf_grants        = grants_q;
  assign bus.perf_hazard_stalls = hazard_q;
  assign bus.perf_out_stalls    = ostall_q;

endmodule

// File: tb/tb_rf_access_scheduler.sv
// tb/tb_rf_access_scheduler.sv - random issue/writeback traffic against a behavioural scheduler model
module tb_rf_access_scheduler;

  localparam int NR  = 4;
  localparam int TPW = 32;
  localparam int DW  = TPW * 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_access_scheduler_if #(.NUM_REQ(NR), .THREADS_PER_WARP(TPW)) bus ();

  rf_access_scheduler #(
    .NUM_REQ(NR), .NUM_WARPS(32), .NUM_REGISTERS(32), .THREADS_PER_WARP(TPW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] rf_pattern(input logic [5:0] w, input logic [4:0] r,
                                               input logic port);
    logic [DW-1:0] d;
    for (int t = 0; t < TPW; t++) d[t*32 +: 32] = {w, r, port, 5'(t), 15'h1234};
    return d;
  endfunction

  assign bus.rf_rs1_data = rf_pattern(bus.rf_rs1_warp, bus.rf_rs1_addr, 1'b0);
  assign bus.rf_rs2_data = rf_pattern(bus.rf_rs2_warp, bus.rf_rs2_addr, 1'b1);

  function automatic logic [63:0] fold(input logic [DW-1:0] d);
    logic [31:0] x, s;
    x = '0;
    s = '0;
    for (int t = 0; t < TPW; t++) begin
      x = x ^ d[t*32 +: 32];
      s = {s[30:0], s[31]} + d[t*32 +: 32];
    end
    return {x, s};
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: what the scoreboard, pointer, slot and counters should hold.
  bit          busy_m [32][32];
  int          ptr_m;
  bit          ov_m;
  int          oid_m;
  logic [5:0]  ow_m;
  logic [4:0]  ord_m;
  bit          owr_m;
  logic [63:0] oa_m, ob_m;
  logic [31:0] pg_m, ph_m, po_m;

  task automatic model_reset();
    foreach (busy_m[w, r]) busy_m[w][r] = 1'b0;
    ptr_m = 0; ov_m = 1'b0; oid_m = 0; ow_m = '0; ord_m = '0; owr_m = 1'b0;
    oa_m = '0; ob_m = '0; pg_m = '0; ph_m = '0; po_m = '0;
  endtask

  task automatic pick_target(output logic [5:0] w, output logic [4:0] r);
    int q[$];
    for (int i = 0; i < 4; i++)
      for (int j = 1; j < 8; j++)
        if (busy_m[i][j]) q.push_back(i * 32 + j);
    if (q.size() > 0 && $urandom_range(0, 99) < 75) begin
      int e;
      e = q[$urandom_range(0, q.size() - 1)];
      w = 6'(e / 32);
      r = 5'(e % 32);
    end else begin
      w = 6'($urandom_range(0, 3));
      r = 5'($urandom_range(0, 7));
    end
  endtask

  task automatic drive_random();
    logic [5:0] w;
    logic [4:0] r;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = ($urandom_range(0, 99) < 60);
      bus.req_warp[i]  = 6'($urandom_range(0, 3));
      bus.req_rs1[i]   = 5'($urandom_range(0, 7));
      bus.req_rs2[i]   = 5'($urandom_range(0, 7));
      bus.req_rd[i]    = 5'($urandom_range(0, 7));
      bus.req_wr[i]    = 1'($urandom_range(0, 1));
    end
    bus.out_ready = ($urandom_range(0, 99) < 70);
    pick_target(w, r);
    bus.wb_mem_valid = ($urandom_range(0, 99) < 30);
    bus.wb_mem_warp  = w;
    bus.wb_mem_rd    = r;
    bus.wb_mem_data  = {TPW{$urandom()}};
    bus.wb_mem_mask  = $urandom();
    pick_target(w, r);
    bus.wb_alu_valid = ($urandom_range(0, 99) < 40);
    bus.wb_alu_warp  = w;
    bus.wb_alu_rd    = r;
    bus.wb_alu_data  = {TPW{$urandom()}};
    bus.wb_alu_mask  = $urandom();
  endtask

  // Checks the combinational outputs for the current inputs, then advances the model one edge.
  task automatic step_model(input bit upd);
    bit          el [NR];
    bit          any_v, any_e, mem_acc, alu_acc, exp_we;
    int          gid;
    logic [NR-1:0] exp_rdy;
    logic [4:0]  e_rs1, e_rs2, e_rd, w_rd;
    logic [5:0]  e_w, w_w;
    logic [31:0] w_mask;
    logic [DW-1:0] w_data;
    bit          e_wr;
    any_v = 1'b0;
    any_e = 1'b0;
    for (int i = 0; i < NR; i++) begin
      int w;
      w = int'(bus.req_warp[i]);
      el[i] = bus.req_valid[i] && !busy_m[w][int'(bus.req_rs1[i])]
           && !busy_m[w][int'(bus.req_rs2[i])]
           && !(bus.req_wr[i] && busy_m[w][int'(bus.req_rd[i])]);
      any_v |= bus.req_valid[i];
      any_e |= el[i];
    end
    gid = -1;
    if (!ov_m || bus.out_ready)
      for (int k = 0; k < NR; k++)
        if (gid < 0 && el[(ptr_m + k) % NR]) gid = (ptr_m + k) % NR;
    exp_rdy = '0;
    e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_w = '0; e_wr = 1'b0;
    if (gid >= 0) begin
      exp_rdy[gid] = 1'b1;
      e_rs1 = bus.req_rs1[gid]; e_rs2 = bus.req_rs2[gid]; e_rd = bus.req_rd[gid];
      e_w = bus.req_warp[gid]; e_wr = bus.req_wr[gid];
    end
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    check("rf_rs1_addr", 64'(bus.rf_rs1_addr), 64'(e_rs1));
    check("rf_rs2_addr", 64'(bus.rf_rs2_addr), 64'(e_rs2));
    check("rf_rs1_warp", 64'(bus.rf_rs1_warp), 64'(e_w));
    check("rf_rs2_warp", 64'(bus.rf_rs2_warp), 64'(e_w));

    mem_acc = bus.wb_mem_valid;
    alu_acc = bus.wb_alu_valid && !bus.wb_mem_valid;
    check("wb_mem_ready", 64'(bus.wb_mem_ready), 64'd1);
    check("wb_alu_ready", 64'(bus.wb_alu_ready), 64'(!bus.wb_mem_valid));
    w_w = mem_acc ? bus.wb_mem_warp : bus.wb_alu_warp;
    w_rd = mem_acc ? bus.wb_mem_rd : bus.wb_alu_rd;
    w_mask = mem_acc ? bus.wb_mem_mask : bus.wb_alu_mask;
    w_data = mem_acc ? bus.wb_mem_data : bus.wb_alu_data;
    exp_we = (mem_acc || alu_acc) && (w_rd != 0);
    check("rf_write_en", 64'(bus.rf_write_en), 64'(exp_we));
    if (exp_we) begin
      check("rf_rd_addr", 64'(bus.rf_rd_addr), 64'(w_rd));
      check("rf_rd_warp", 64'(bus.rf_rd_warp), 64'(w_w));
      check("rf_rd_mask", 64'(bus.rf_rd_thread_mask), 64'(w_mask));
      check("rf_rd_data", fold(bus.rf_rd_data), fold(w_data));
    end
    if (!upd) return;

    if (mem_acc || alu_acc) busy_m[int'(w_w)][int'(w_rd)] = 1'b0;
    if (gid >= 0 && e_wr && e_rd != 0) busy_m[int'(e_w)][int'(e_rd)] = 1'b1;
    if (gid >= 0) pg_m++;
    if (any_v && !any_e) ph_m++;
    if (ov_m && !bus.out_ready) po_m++;
    if (gid >= 0) begin
      ov_m = 1'b1; oid_m = gid; ow_m = e_w; ord_m = e_rd; owr_m = e_wr;
      oa_m = fold(rf_pattern(e_w, e_rs1, 1'b0));
      ob_m = fold(rf_pattern(e_w, e_rs2, 1'b1));
      ptr_m = (gid + 1) % NR;
    end else if (bus.out_ready) begin
      ov_m = 1'b0;
    end
  endtask

  task automatic check_regs(input string pfx);
    check({pfx, "out_valid"}, 64'(bus.out_valid), 64'(ov_m));
    if (ov_m) begin
      check({pfx, "out_req_id"}, 64'(bus.out_req_id), 64'(oid_m));
      check({pfx, "out_warp"}, 64'(bus.out_warp), 64'(ow_m));
      check({pfx, "out_rd"}, 64'(bus.out_rd), 64'(ord_m));
      check({pfx, "out_wr"}, 64'(bus.out_wr), 64'(owr_m));
      check({pfx, "out_op_a"}, fold(bus.out_op_a), oa_m);
      check({pfx, "out_op_b"}, fold(bus.out_op_b), ob_m);
    end
    check({pfx, "perf_grants"}, 64'(bus.perf_grants), 64'(pg_m));
    check({pfx, "perf_hazard"}, 64'(bus.perf_hazard_stalls), 64'(ph_m));
    check({pfx, "perf_out"}, 64'(bus.perf_out_stalls), 64'(po_m));
  endtask

  initial begin
    bus.req_valid = '0; bus.req_warp = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
    bus.req_rd = '0; bus.req_wr = '0; bus.out_ready = 1'b0;
    bus.wb_alu_valid = 1'b0; bus.wb_alu_warp = '0; bus.wb_alu_rd = '0;
    bus.wb_alu_data = '0; bus.wb_alu_mask = '0;
    bus.wb_mem_valid = 1'b0; bus.wb_mem_warp = '0; bus.wb_mem_rd = '0;
    bus.wb_mem_data = '0; bus.wb_mem_mask = '0;
    model_reset();

    repeat (2) @(negedge clk);
    check_regs("reset_");
    step_model(1'b0);
    // Combinational rules still apply while held in reset, starting from the zeroed state.
    drive_random();
    #1;
    step_model(1'b0);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive_random();
      if (cyc == 1000) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("midrst_");
        step_model(1'b0);
        @(posedge clk);
        #1;
        check_regs("midrst_hold_");
      end else begin
        #1;
        step_model(1'b1);
        @(posedge clk);
        #1;
        check_regs("");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
